// File: rtl/switch_traffic_stats.sv
// Per-port and global traffic accounting for the N-port switch.
// Each port lane keeps weighted accepted/dropped counts and a delivered count.
// The top tracks the global in-flight count, the sticky error flags and a
// one-cycle-latency read port over the snapshot registers.

module switch_traffic_stats_lane #(
  parameter int NUM_PORTS = 4,
  parameter int CNT_W     = 32,
  parameter int WW        = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 snap,
  input  logic                 in_valid,
  input  logic                 in_full,
  input  logic [NUM_PORTS-1:0] in_target,
  input  logic                 out_valid,
  output logic [WW-1:0]        acc_w,
  output logic                 sat,
  output logic [CNT_W-1:0]     acc_s,
  output logic [CNT_W-1:0]     drop_s,
  output logic [CNT_W-1:0]     dlv_s
);
  logic [CNT_W-1:0] acc, drop, dlv;
  logic [WW-1:0]    w, drop_w;
  logic [CNT_W:0]   acc_sum, drop_sum, dlv_sum;

  // Event weight is the fan-out of the target mask; the carry bit of each sum flags saturation.
  always_comb begin
    w = '0;
    for (int i = 0; i < NUM_PORTS; i++) w = w + WW'(in_target[i]);
    acc_w    = (in_valid && !in_full) ? w : '0;
    drop_w   = (in_valid &&  in_full) ? w : '0;
    acc_sum  = {1'b0, acc}  + (CNT_W+1)'(acc_w);
    drop_sum = {1'b0, drop} + (CNT_W+1)'(drop_w);
    dlv_sum  = {1'b0, dlv}  + (CNT_W+1)'(out_valid);
    sat      = acc_sum[CNT_W] | drop_sum[CNT_W] | dlv_sum[CNT_W];
  end

  // Saturating live counters; the snapshot takes the pre-update values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0; drop <= '0; dlv <= '0;
      acc_s <= '0; drop_s <= '0; dlv_s <= '0;
    end else if (clear) begin
      acc <= '0; drop <= '0; dlv <= '0;
      acc_s <= '0; drop_s <= '0; dlv_s <= '0;
    end else begin
      acc  <= acc_sum[CNT_W]  ? '1 : acc_sum[CNT_W-1:0];
      drop <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
      dlv  <= dlv_sum[CNT_W]  ? '1 : dlv_sum[CNT_W-1:0];
      if (snap) begin
        acc_s <= acc; drop_s <= drop; dlv_s <= dlv;
      end
    end
  end
endmodule

module switch_traffic_stats #(
  parameter int NUM_PORTS = 4,
  parameter int CNT_W     = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_PORTS-1:0]           in_valid,
  input  logic [NUM_PORTS-1:0]           in_full,
  input  logic [NUM_PORTS*NUM_PORTS-1:0] in_target,
  input  logic [NUM_PORTS-1:0]           out_valid,
  input  logic                           clear,
  input  logic                           snap,
  input  logic                           rd_en,
  input  logic [$clog2(NUM_PORTS)-1:0]   rd_port,
  input  logic [1:0]                     rd_sel,
  output logic                           rd_valid,
  output logic [CNT_W-1:0]               rd_data,
  output logic [CNT_W-1:0]               in_flight,
  output logic                           idle,
  output logic                           err_underflow,
  output logic                           err_sat
);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int WW = $clog2(NUM_PORTS+1);
  localparam int SW = $clog2(NUM_PORTS*NUM_PORTS+1);
  localparam int IW = CNT_W + SW + 1;

  logic [NUM_PORTS-1:0][WW-1:0]    acc_w;
  logic [NUM_PORTS-1:0]            lane_sat;
  logic [NUM_PORTS-1:0][CNT_W-1:0] acc_s, drop_s, dlv_s;
  logic [CNT_W-1:0]                snap_if, rd_mux;
  logic [SW-1:0]                   acc_tot, dlv_cnt;
  logic signed [IW-1:0]            if_next;
  logic                            if_uf, if_ov;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_lane
    switch_traffic_stats_lane #(.NUM_PORTS(NUM_PORTS), .CNT_W(CNT_W), .WW(WW)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .snap      (snap),
      .in_valid  (in_valid[p]),
      .in_full   (in_full[p]),
      .in_target (in_target[p*NUM_PORTS +: NUM_PORTS]),
      .out_valid (out_valid[p]),
      .acc_w     (acc_w[p]),
      .sat       (lane_sat[p]),
      .acc_s     (acc_s[p]),
      .drop_s    (drop_s[p]),
      .dlv_s     (dlv_s[p])
    );
  end

  // Net in-flight change in a wide signed domain so underflow and overflow both show up.
  always_comb begin
    acc_tot = '0;
    dlv_cnt = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      acc_tot = acc_tot + SW'(acc_w[p]);
      dlv_cnt = dlv_cnt + SW'(out_valid[p]);
    end
    if_next = IW'(in_flight) + IW'(acc_tot) - IW'(dlv_cnt);
    if_uf   = if_next[IW-1];
    if_ov   = !if_next[IW-1] && (|if_next[IW-2:CNT_W]);
  end

  // Snapshot read mux; a port index with no lane behind it reads as zero.
  always_comb begin
    rd_mux = '0;
    if (rd_sel == 2'd3) rd_mux = snap_if;
    else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (rd_port == PW'(p)) begin
          case (rd_sel)
            2'd0:    rd_mux = acc_s[p];
            2'd1:    rd_mux = drop_s[p];
            default: rd_mux = dlv_s[p];
          endcase
        end
      end
    end
  end

  assign idle = (in_flight == '0) && !(|in_valid) && !(|out_valid);

  // Global in-flight count, sticky flags and the registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flight     <= '0;
      snap_if       <= '0;
      err_underflow <= 1'b0;
      err_sat       <= 1'b0;
      rd_valid      <= 1'b0;
      rd_data       <= '0;
    end else if (clear) begin
      in_flight     <= '0;
      snap_if       <= '0;
      err_underflow <= 1'b0;
      err_sat       <= 1'b0;
      rd_valid      <= rd_en;
      rd_data       <= '0;
    end else begin
      in_flight     <= if_uf ? '0 : (if_ov ? '1 : if_next[CNT_W-1:0]);
      if (snap) snap_if <= in_flight;
      err_underflow <= err_underflow | if_uf;
      err_sat       <= err_sat | if_ov | (|lane_sat);
      rd_valid      <= rd_en;
      if (rd_en) rd_data <= rd_mux;
    end
  end
endmodule

// File: doc/switch_traffic_stats.md
# switch_traffic_stats

Parametrised hardware traffic-accounting block for the N-port switch. It sits beside the switch, tapping each port's ingress handshake (valid, FIFO-full, target mask) and each egress valid. It keeps per-port weighted accepted/dropped counts, per-port delivered counts and a global in-flight count, so drop and internal-loss accounting is done in silicon instead of by bench-side counters. Software and the bench read a coherent snapshot through a one-cycle-latency read port.

## Interface
- NUM_PORTS, 4, number of switch ports (2..16)
- CNT_W, 32, width of every counter (8..64)
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  NUM_PORTS  per-port ingress valid (bit p = port p)
- in_full  in  NUM_PORTS  per-port ingress FIFO full at that cycle
- in_target  in  NUM_PORTS*NUM_PORTS  target masks, port p at bits [p*NUM_PORTS +: NUM_PORTS]
- out_valid  in  NUM_PORTS  per-port egress valid, one packet per asserted bit per cycle
- clear  in  1  synchronous clear of all counters, snapshot and sticky flags
- snap  in  1  copy live counters into snapshot registers
- rd_en  in  1  read request
- rd_port  in  $clog2(NUM_PORTS)  port index to read
- rd_sel  in  2  0 accepted, 1 dropped, 2 delivered, 3 global in-flight (rd_port ignored)
- rd_valid  out  1  read data valid
- rd_data  out  CNT_W  snapshot value
- in_flight  out  CNT_W  live global in-flight count
- idle  out  1  in_flight==0 and no in_valid/out_valid this cycle
- err_underflow  out  1  sticky: delivery exceeded accepted total
- err_sat  out  1  sticky: any counter saturated

## Operation
- Weight of an ingress event on port p: w_p = popcount(in_target[p]); masks of 0 give weight 0.
- in_valid[p] && !in_full[p]: acc[p] += w_p. in_valid[p] && in_full[p]: drop[p] += w_p.
- out_valid[p]: dlv[p] += 1.
- in_flight_next = in_flight + sum(accepted weights this cycle) − popcount(out_valid). Use a width of CNT_W+$clog2(NUM_PORTS*NUM_PORTS+1)+1 signed intermediate.
- If in_flight_next < 0: in_flight clamps to 0 and err_underflow sets.
- acc, drop and dlv saturate at 2^CNT_W−1 and never wrap. in_flight saturates likewise. Any saturation sets err_sat.
- snap: snapshot registers take the live values as they stood before this cycle's updates.
- clear has priority over everything. All live counters, snapshots, in_flight, err_underflow and err_sat go to 0, and the clear cycle's events are discarded.
- snap together with clear: the snapshot is zeroed.
- Read: rd_en samples rd_port and rd_sel and returns the snapshot value. If rd_port ≥ NUM_PORTS, rd_data = 0 and rd_valid still asserts.
- rd_en together with snap: returns the old snapshot.
- rd_en together with clear: returns 0.

## Timing
- Reset (async assert, sync-free deassert):
  - rd_valid=0, rd_data=0, in_flight=0, err_underflow=0, err_sat=0.
  - All counters and snapshots = 0.
  - idle=1 once inputs are quiet.
- Event in cycle N: live counter and in_flight visible at cycle N+1.
- idle is combinational on in_valid/out_valid and the registered in_flight.
- rd_en in cycle N: rd_valid=1 and rd_data valid in N+1, for one cycle only. Back-to-back reads are supported, one per cycle.
- Sticky flags rise in the cycle after the triggering event. Only reset or clear lowers them.
- Reset mid-operation: immediate zeroing. No partial update survives.

## Test plan
- Port 0 sends 3 accepted packets, target 4'b0111, in_full=0; snap; read (0,0) -> rd_data=9. in_flight=9 before any delivery.
- Port 2 sends 2 packets, target 4'b1011, with in_full=1; snap; read (2,1) -> 6. Read (2,0) -> 0. in_flight unchanged.
- In the same cycle: all 4 ports ingress with target 4'b0001, and out_valid=4'b1111 with prior in_flight=4 -> next in_flight=4. Then dlv[p]=1 each and idle=0.
- out_valid=4'b0001 with in_flight=0 -> in_flight stays 0, err_underflow=1 next cycle. It persists until clear.
- CNT_W=8: 300 accepted weight-1 events on port 1 -> acc[1]=255, err_sat=1. clear -> all reads 0, flags 0.
- snap and rd_en(sel 3) in the same cycle after 5 accepted -> rd_data = previous snapshot (0). A following read -> 5. Assert rst_n mid-stream -> all outputs 0 asynchronously.
